mult_result_bcd: RTL and testbench
==================================

Name: mult_result_bcd

Overview:
Downstream stage of the 8x8 shift-add multiplier. Captures the 16-bit product when the multiplier controller raises done_flag, then converts it serially to packed BCD using double-dabble, one adjust+shift per clock. Holds the result for the display/readout logic with a valid/ack handshake. Buffers one pending product so back-to-back multiplications are not lost.

Parameters:
WIDTH, 16, binary input width; matches the product8_8 width.
DIGITS, 5, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset_a  in  1  synchronous, active-high reset.
done_flag  in  1  multiplier done level; only a rising edge starts a capture.
product8_8  in  WIDTH  product, sampled in the same cycle the done_flag rising edge is detected.
bcd_ack  in  1  consumer acknowledge; clears bcd_valid.
bcd_digits  out  DIGITS*4  packed BCD; digit 0 at bits [3:0]; holds until the next conversion completes.
bcd_valid  out  1  high from conversion completion until acknowledged.
busy  out  1  high while a conversion is in progress.
overrun  out  1  sticky; a pending product was overwritten.

Behaviour:
- Reset (clk edge with reset_a=1), whatever the current state:
  - bcd_digits=0, bcd_valid=0, busy=0, overrun=0.
  - pending buffer empty; FSM enters IDLE.
  - done_prev=1, so a done_flag already high at reset release does not trigger a capture.
- Edge detect: done_rise = done_flag & ~done_prev. done_prev <= done_flag every cycle.
- FSM states: IDLE, CONV.
- IDLE:
  - On done_rise at edge N: load the shift register as {DIGITS*4 zeros, product8_8}, iteration count=0, go to CONV, busy=1 after edge N.
  - Otherwise, if pending is valid: load from pending at edge N, clear pending, go to CONV.
- CONV, each cycle:
  - Every 4-bit BCD field >= 5 gets +3.
  - Then the whole register shifts left by 1.
  - count increments.
- Completion: on the WIDTH-th CONV edge (edge N+WIDTH):
  - bcd_digits <= upper DIGITS*4 bits of the post-shift value.
  - bcd_valid <= 1.
  - If pending is valid: load it, clear pending, stay in CONV with busy=1. Otherwise go to IDLE with busy=0.
- Latency: bcd_valid high after edge N+WIDTH, where edge N sampled the rise. Back-to-back conversions give one result every WIDTH cycles.
- done_rise while in CONV: product8_8 goes into pending.
  - If pending is already valid: pending is overwritten with the newer product and overrun <= 1.
  - overrun is cleared only by reset.
- done_rise in the same cycle as completion with pending empty: the new product goes straight into the shift register (no idle gap). With pending full, the pending product is loaded and the new product replaces it in pending; overrun is not set.
- bcd_ack:
  - bcd_ack with bcd_valid=1: bcd_valid <= 0 next edge.
  - bcd_ack in the same cycle as a completion: the completion wins and bcd_valid stays 1 with the new digits.
  - bcd_ack while bcd_valid=0 is ignored.
- No backpressure: a completion overwrites bcd_digits even if the previous result was not acknowledged.
- Width rules: iteration counter is clog2(WIDTH+1) bits. Shift register is DIGITS*4+WIDTH bits. Each +3 is done within 4 bits and never carries out (field value <= 9 after shift).

Decomposition:
- Package mult_bcd_pkg:
  - state enum {IDLE, CONV}.
  - BCD_W = DIGITS*4 constant.
  - ADJ_THRESH = 5 and ADJ_ADD = 3 constants.
  - Function computing the counter width.
- Sub-module bcd_adjust_shift: combinational; takes the current shift register and returns the adjusted+shifted value. It is parameterized by WIDTH/DIGITS and instantiated once.
- The top of the block holds the edge detect, pending buffer, FSM, counter and output registers.

Test Plan:
- Reset with done_flag held high, then release -> no conversion; busy=0, bcd_valid=0, bcd_digits=0 indefinitely.
- done_flag rises with product8_8=16'hFE01 (255*255) -> busy for 16 cycles; after edge N+16, bcd_digits=20'h65025 and bcd_valid=1; bcd_ack one cycle later -> bcd_valid=0, digits retained.
- Single conversions, each checked after edge N+16:
  - 16'h009C -> 20'h00156
  - 16'h270F -> 20'h09999
  - 16'h0000 -> 20'h00000
- Second done rise (16'h0010) 5 cycles into a conversion -> first result at N+16, second result 20'h00016 at N+32, busy continuously high, overrun=0.
- Three rises during one conversion (products 1, 2, 3) -> overrun=1; results delivered are the first product's digits and then 20'h00003 only; value 2 is dropped.
- bcd_ack asserted in the exact completion cycle -> bcd_valid remains 1 with the new digits; reset_a mid-CONV -> all outputs 0 next edge, pending discarded, FSM in IDLE.

Source files
------------

// File: rtl/mult_result_bcd_pkg.sv
// Shared definitions for the product-to-BCD readout stage.
//   state_t       : FSM encoding (IDLE waits for a product, CONV runs double-dabble)
//   BCD_W         : packed BCD width for the default digit count
//   ADJ_THRESH/ADJ_ADD : double-dabble per-digit correction constants
//   bcd_width()   : packed BCD width for a given digit count
//   cnt_width()   : iteration counter width able to hold 0..width
package mult_bcd_pkg;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam int WIDTH_DEFAULT  = 16;
    localparam int DIGITS_DEFAULT = 5;
    localparam int BCD_W          = DIGITS_DEFAULT * 4;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    function automatic int bcd_width(input int digits);
        return digits * 4;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_result_bcd_if.sv
// Handshake bundle between the multiplier, this BCD stage and the readout.
//   done_flag, product8_8 : product delivery from the multiplier controller
//   bcd_ack               : consumer acknowledge
//   bcd_digits, bcd_valid : converted result
//   busy, overrun         : status
// slave  = the BCD stage, master = the surrounding logic.
interface mult_result_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) ();

    logic                  done_flag;
    logic [WIDTH-1:0]      product8_8;
    logic                  bcd_ack;
    logic [DIGITS*4-1:0]   bcd_digits;
    logic                  bcd_valid;
    logic                  busy;
    logic                  overrun;

    modport slave (
        input  done_flag,
        input  product8_8,
        input  bcd_ack,
        output bcd_digits,
        output bcd_valid,
        output busy,
        output overrun
    );

    modport master (
        output done_flag,
        output product8_8,
        output bcd_ack,
        input  bcd_digits,
        input  bcd_valid,
        input  busy,
        input  overrun
    );

endinterface

// File: rtl/mult_result_bcd_adjust_shift.sv
// One double-dabble step: every BCD nibble >= 5 gets +3, then the whole
// register shifts left by one.
//   i_shift : current {BCD digits, remaining binary bits}
//   o_shift : adjusted and shifted value
module bcd_adjust_shift
    import mult_bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic [DIGITS*4+WIDTH-1:0] i_shift,
    output logic [DIGITS*4+WIDTH-1:0] o_shift
);

    logic [DIGITS*4+WIDTH-1:0] w_adj;

    always_comb begin
        w_adj = i_shift;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            // A nibble is at most 9 here, so +3 never leaves the 4-bit field.
            if (i_shift[WIDTH + 4*i +: 4] >= ADJ_THRESH) begin
                w_adj[WIDTH + 4*i +: 4] = i_shift[WIDTH + 4*i +: 4] + ADJ_ADD;
            end
        end
        o_shift = {w_adj[DIGITS*4+WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/mult_result_bcd.sv
// Captures the multiplier product on a done_flag rising edge and converts it
// to packed BCD with one double-dabble step per clock. One product can wait
// in a pending buffer while a conversion runs; a second one overwrites it
// and sets the sticky overrun flag.
//   clk     : system clock, rising edge
//   reset_a : synchronous active-high reset
//   bus     : slave side of mult_result_bcd_if (product in, BCD/status out)
module mult_result_bcd
    import mult_bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic               clk,
    input  logic               reset_a,
    mult_result_bcd_if.slave   bus
);

    localparam int BW    = bcd_width(DIGITS);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int SR_W  = BW + WIDTH;

    state_t             r_state;
    logic [SR_W-1:0]    r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done_prev;
    logic               r_pend_valid;
    logic [WIDTH-1:0]   r_pend_data;
    logic [BW-1:0]      r_digits;
    logic               r_valid;
    logic               r_busy;
    logic               r_overrun;

    logic               w_rise;
    logic               w_last;
    logic [SR_W-1:0]    w_next;

    assign w_rise = bus.done_flag & ~r_done_prev;
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    bcd_adjust_shift #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_adjust_shift (
        .i_shift (r_shift),
        .o_shift (w_next)
    );

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_done_prev  <= 1'b1;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_digits     <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done_prev <= bus.done_flag;

            // Completion below overrides this, so an ack in the completion
            // cycle leaves the new result valid.
            if (bus.bcd_ack && r_valid) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_shift <= {{BW{1'b0}}, bus.product8_8};
                        r_cnt   <= '0;
                        r_state <= CONV;
                        r_busy  <= 1'b1;
                    end else if (r_pend_valid) begin
                        r_shift      <= {{BW{1'b0}}, r_pend_data};
                        r_cnt        <= '0;
                        r_pend_valid <= 1'b0;
                        r_state      <= CONV;
                        r_busy       <= 1'b1;
                    end
                end
                CONV: begin
                    if (w_last) begin
                        r_digits <= w_next[SR_W-1 -: BW];
                        r_valid  <= 1'b1;
                        r_cnt    <= '0;
                        // Pending is older than a product arriving now, so it
                        // goes first; the new one takes its slot without overrun.
                        if (r_pend_valid) begin
                            r_shift <= {{BW{1'b0}}, r_pend_data};
                            if (w_rise) begin
                                r_pend_data <= bus.product8_8;
                            end else begin
                                r_pend_valid <= 1'b0;
                            end
                        end else if (w_rise) begin
                            r_shift <= {{BW{1'b0}}, bus.product8_8};
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_shift <= w_next;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_rise) begin
                            r_pend_data  <= bus.product8_8;
                            r_pend_valid <= 1'b1;
                            if (r_pend_valid) begin
                                r_overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bcd_digits = r_digits;
    assign bus.bcd_valid  = r_valid;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_mult_result_bcd.sv
module tb_mult_result_bcd;

    logic clk;
    logic reset_a;
    int   checks;
    int   errors;

    mult_result_bcd_if #(.WIDTH(16), .DIGITS(5)) bus ();

    mult_result_bcd #(
        .WIDTH  (16),
        .DIGITS (5)
    ) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rise done_flag with product p at the next edge (edge N), drop it again.
    task automatic pulse(input logic [15:0] p);
        bus.done_flag  = 1'b1;
        bus.product8_8 = p;
        tick();
        bus.done_flag  = 1'b0;
    endtask

    // Single conversion from idle with bcd_valid low beforehand, then ack.
    task automatic single(input string tag, input logic [15:0] p, input logic [19:0] exp);
        pulse(p);
        check({tag, "_busy_N"}, 32'(bus.busy), 32'd1);
        repeat (15) tick();
        check({tag, "_valid_N15"}, 32'(bus.bcd_valid), 32'd0);
        tick();
        check({tag, "_digits"}, 32'(bus.bcd_digits), 32'(exp));
        check({tag, "_valid"}, 32'(bus.bcd_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        bus.bcd_ack = 1'b1;
        tick();
        bus.bcd_ack = 1'b0;
        check({tag, "_acked"}, 32'(bus.bcd_valid), 32'd0);
        check({tag, "_kept"}, 32'(bus.bcd_digits), 32'(exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_a        = 1'b1;
        bus.done_flag  = 1'b1;
        bus.product8_8 = 16'h1234;
        bus.bcd_ack    = 1'b0;

        // Reset with done_flag already high: no capture after release.
        tick();
        tick();
        check("rst_valid", 32'(bus.bcd_valid), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        reset_a = 1'b0;
        repeat (20) tick();
        check("hold_busy", 32'(bus.busy), 32'd0);
        check("hold_valid", 32'(bus.bcd_valid), 32'd0);
        check("hold_digits", 32'(bus.bcd_digits), 32'd0);
        bus.done_flag = 1'b0;
        tick();

        single("fe01", 16'hFE01, 20'h65025);
        single("009c", 16'h009C, 20'h00156);
        single("270f", 16'h270F, 20'h09999);
        single("0000", 16'h0000, 20'h00000);

        // Second product arrives 5 cycles in; queued and run straight after.
        pulse(16'h0007);
        repeat (4) tick();
        pulse(16'h0010);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("b2b_busy", 32'(bus.busy), 32'd1);
        end
        tick();
        check("b2b_first", 32'(bus.bcd_digits), 32'h00007);
        check("b2b_first_v", 32'(bus.bcd_valid), 32'd1);
        check("b2b_busy16", 32'(bus.busy), 32'd1);
        repeat (15) tick();
        check("b2b_mid_v", 32'(bus.bcd_valid), 32'd1);
        check("b2b_mid_d", 32'(bus.bcd_digits), 32'h00007);
        tick();
        check("b2b_second", 32'(bus.bcd_digits), 32'h00016);
        check("b2b_second_v", 32'(bus.bcd_valid), 32'd1);
        check("b2b_idle", 32'(bus.busy), 32'd0);
        check("b2b_overrun", 32'(bus.overrun), 32'd0);

        // Ack coincides with completion: the new result stays valid.
        pulse(16'h009C);
        repeat (15) tick();
        bus.bcd_ack = 1'b1;
        tick();
        bus.bcd_ack = 1'b0;
        check("ackc_valid", 32'(bus.bcd_valid), 32'd1);
        check("ackc_digits", 32'(bus.bcd_digits), 32'h00156);
        bus.bcd_ack = 1'b1;
        tick();
        bus.bcd_ack = 1'b0;
        check("ackc_clear", 32'(bus.bcd_valid), 32'd0);

        // Three rises in one conversion window: 2 is overwritten by 3.
        pulse(16'h0001);
        tick();
        pulse(16'h0002);
        check("ovr_before", 32'(bus.overrun), 32'd0);
        tick();
        pulse(16'h0003);
        check("ovr_set", 32'(bus.overrun), 32'd1);
        repeat (12) tick();
        check("ovr_first", 32'(bus.bcd_digits), 32'h00001);
        check("ovr_first_v", 32'(bus.bcd_valid), 32'd1);
        repeat (16) tick();
        check("ovr_second", 32'(bus.bcd_digits), 32'h00003);
        check("ovr_idle", 32'(bus.busy), 32'd0);
        repeat (20) tick();
        check("ovr_no_more", 32'(bus.bcd_digits), 32'h00003);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Reset mid-conversion with a pending product: everything discarded.
        pulse(16'h270F);
        repeat (3) tick();
        pulse(16'h0042);
        repeat (2) tick();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_valid", 32'(bus.bcd_valid), 32'd0);
        check("mrst_digits", 32'(bus.bcd_digits), 32'd0);
        check("mrst_overrun", 32'(bus.overrun), 32'd0);
        repeat (40) tick();
        check("mrst_pend_busy", 32'(bus.busy), 32'd0);
        check("mrst_pend_valid", 32'(bus.bcd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
